// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets
// and bit positions inside the console STATUS word.
package dmem_pkg;

    localparam logic [15:0] OFF_GPIO   = 16'h0000;
    localparam logic [15:0] OFF_TX     = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_CYC_LO = 16'h000C;
    localparam logic [15:0] OFF_CYC_HI = 16'h0010;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] MAX_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == MAX_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // When full with push+pop, wr_ptr equals rd_ptr: the head is consumed this
    // cycle, so overwriting its slot at the edge keeps order intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for the single-cycle core: word RAM plus an MMIO block
// with GPIO, a free-running 64-bit cycle counter and a console transmit FIFO.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS  = 256,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] addr,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic              mmio_sel;
    logic [15:0]       offset;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              mmio_we;

    logic [63:0]       cycle_cnt;
    logic              overflow;
    logic [31:0]       status;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        fifo_dout;
    logic              ovf_event;
    logic              ovf_clear;

    assign mmio_sel = (addr[31:16] == MMIO_BASE[31:16]);
    assign offset   = addr[15:0];
    assign ram_idx  = addr[RAM_AW+1:2];
    assign ram_we   = dmem_wren && !mmio_sel;
    assign mmio_we  = dmem_wren && mmio_sel;

    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_dout;
    assign fifo_push = mmio_we && (offset == OFF_TX);
    assign fifo_pop  = tx_valid && tx_ready && !reset;
    assign ovf_event = fifo_push && fifo_full && !fifo_pop;
    assign ovf_clear = mmio_we && (offset == OFF_STATUS) && dmem_data_in[ST_OVF];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dmem_data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // RAM is deliberately left out of reset so a core reset preserves data.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= dmem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out  <= '0;
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (mmio_we && (offset == OFF_GPIO)) begin
                gpio_out <= dmem_data_in;
            end
            if (mmio_we && (offset == OFF_CYC_LO)) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            // A fresh overflow beats a simultaneous clear.
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_FULL]              = fifo_full;
        status[ST_EMPTY]             = fifo_empty;
        status[ST_OVF]               = overflow;
        status[ST_CNT_LSB +: CNT_W]  = fifo_count;
    end

    always_comb begin
        dmem_data_out = ram[ram_idx];
        if (mmio_sel) begin
            case (offset)
                OFF_GPIO:   dmem_data_out = gpio_out;
                OFF_STATUS: dmem_data_out = status;
                OFF_CYC_LO: dmem_data_out = cycle_cnt[31:0];
                OFF_CYC_HI: dmem_data_out = cycle_cnt[63:32];
                default:    dmem_data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a queue/array reference model checked
// every cycle, plus directed vectors with hand-computed literal results.
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'h0001_0000;

    logic        clk;
    logic        reset;
    logic        dmem_wren;
    logic [31:0] addr;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 0;
    bit cnt_load_req = 0;

    logic [31:0] m_ram   [256];
    bit          m_known [256];
    logic [31:0] m_gpio = '0;
    logic [63:0] m_cnt  = '0;
    logic [7:0]  m_q [$];
    bit          m_ovf  = 0;

    dmem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_wren     (dmem_wren),
        .addr          (addr),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .gpio_out      (gpio_out),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one access for a single clock edge; returns just after the next falling edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d);
        dmem_wren    = wr;
        addr         = a;
        dmem_data_in = d;
        @(negedge clk);
        #1;
        dmem_wren = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] expected);
        addr = a;
        #1;
        checkOutput(name, dmem_data_out, expected);
    endtask

    // Reference model: the memory map expressed directly with arrays and a queue.
    always @(posedge clk) begin : model
        bit          is_mmio;
        logic [15:0] off;
        int          pre;
        bit          popq;
        bit          pushq;
        is_mmio = (addr[31:16] == 16'h0001);
        off     = addr[15:0];
        pre     = m_q.size();
        if (dmem_wren && !is_mmio) begin
            m_ram[addr[9:2]]   = dmem_data_in;
            m_known[addr[9:2]] = 1'b1;
        end
        if (reset) begin
            m_q.delete();
            m_ovf  = 0;
            m_gpio = '0;
            m_cnt  = '0;
        end else begin
            popq  = (pre > 0) && tx_ready;
            pushq = dmem_wren && is_mmio && (off == 16'h0004);
            if (dmem_wren && is_mmio && off == 16'h000C) m_cnt = '0;
            else if (cnt_load_req)                       m_cnt = 64'h0000_0000_FFFF_FFFF + 64'd1;
            else                                         m_cnt = m_cnt + 64'd1;
            if (dmem_wren && is_mmio && off == 16'h0000) m_gpio = dmem_data_in;
            if (dmem_wren && is_mmio && off == 16'h0008 && dmem_data_in[2]) m_ovf = 0;
            if (popq) void'(m_q.pop_front());
            if (pushq) begin
                if (pre < 4 || popq) m_q.push_back(dmem_data_in[7:0]);
                else                 m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_rd;
        bit          rd_known;
        if (checking) begin
            checkOutput("gpio_out", gpio_out, m_gpio);
            checkOutput("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) checkOutput("tx_data", 32'(tx_data), 32'(m_q[0]));
            rd_known = 1'b1;
            exp_rd   = '0;
            if (addr[31:16] == 16'h0001) begin
                case (addr[15:0])
                    16'h0000: exp_rd = m_gpio;
                    16'h0008: exp_rd = {24'd0, 4'(m_q.size()), 1'b0, m_ovf,
                                        m_q.size() == 0, m_q.size() == 4};
                    16'h000C: exp_rd = m_cnt[31:0];
                    16'h0010: exp_rd = m_cnt[63:32];
                    default:  exp_rd = '0;
                endcase
            end else begin
                rd_known = m_known[addr[9:2]];
                exp_rd   = m_ram[addr[9:2]];
            end
            if (rd_known) checkOutput("rd_data", dmem_data_out, exp_rd);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] drain_a [4];
        logic [7:0] drain_b [4];
        drain_a = '{8'h41, 8'h42, 8'h43, 8'h44};
        drain_b = '{8'h62, 8'h63, 8'h64, 8'h55};
        reset        = 1'b1;
        dmem_wren    = 1'b0;
        addr         = '0;
        dmem_data_in = '0;
        tx_ready     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gpio", gpio_out, 32'h0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
        readCheck("rst_status", MMIO + 32'h8, 32'h0000_0002);
        checking = 1;
        reset    = 1'b0;

        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_0013, 32'hCAFE_F00D);
        readCheck("ram_byte_off", 32'h0000_0010, 32'hCAFE_F00D);

        applyStimulus(1'b1, MMIO, 32'h1234_5678);
        checkOutput("gpio_write", gpio_out, 32'h1234_5678);
        readCheck("gpio_read", MMIO, 32'h1234_5678);
        applyStimulus(1'b1, MMIO + 32'h14, 32'hFFFF_FFFF);
        readCheck("unmapped", MMIO + 32'h14, 32'h0);
        readCheck("tx_read", MMIO + 32'h4, 32'h0);

        applyStimulus(1'b1, MMIO + 32'hC, 32'h0);
        addr = MMIO + 32'hC;
        @(negedge clk);
        #1;
        readCheck("cyc_t1", MMIO + 32'hC, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        readCheck("cyc_t5", MMIO + 32'hC, 32'd5);

        cnt_load_req = 1;
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        @(posedge clk);
        #1;
        cnt_load_req = 0;
        readCheck("cyc_wrap_lo", MMIO + 32'hC, 32'h0);
        readCheck("cyc_wrap_hi", MMIO + 32'h10, 32'h1);
        @(negedge clk);
        #1;

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, MMIO + 32'h4, 32'(drain_a[i]));
        readCheck("status_full", MMIO + 32'h8, 32'h41);
        applyStimulus(1'b1, MMIO + 32'h4, 32'h45);
        readCheck("status_ovf", MMIO + 32'h8, 32'h45);
        applyStimulus(1'b1, MMIO + 32'h8, 32'h4);
        readCheck("status_clr", MMIO + 32'h8, 32'h41);
        checkOutput("hold_head", 32'(tx_data), 32'h41);

        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", 32'(tx_valid), 32'h1);
            checkOutput("drain_data", 32'(tx_data), 32'(drain_a[i]));
            @(negedge clk);
            #1;
        end
        checkOutput("drain_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, MMIO + 32'h4, 32'h61 + 32'(i));
        tx_ready = 1'b1;
        applyStimulus(1'b1, MMIO + 32'h4, 32'h55);
        readCheck("full_pushpop_status", MMIO + 32'h8, 32'h41);
        for (int i = 0; i < 4; i++) begin
            checkOutput("pushpop_data", 32'(tx_data), 32'(drain_b[i]));
            @(negedge clk);
            #1;
        end
        checkOutput("pushpop_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        applyStimulus(1'b1, 32'h0000_0020, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, MMIO + 32'h4, 32'h71 + 32'(i));
        applyStimulus(1'b1, MMIO, 32'h0000_00FF);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 32'(tx_valid), 32'h0);
        checkOutput("mid_rst_gpio", gpio_out, 32'h0);
        readCheck("mid_rst_status", MMIO + 32'h8, 32'h0000_0002);
        readCheck("mid_rst_ram20", 32'h0000_0020, 32'hA5A5_0001);
        readCheck("mid_rst_ram10", 32'h0000_0010, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        #1;

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
